sweep_ctrl: RTL and testbench

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_ctrl_if.sv | 41 ++++
 rtl/sweep_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sweep_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if: groups the control, configuration, sample and result signals
// that pass between the frequency-sweep controller and its environment.
//   master : drives start/abort, sweep configuration, decimated samples, res_ready
//   slave  : drives phase_inc, busy, the result channel and the done pulse
// Clock and reset are kept outside the interface as plain ports.
interface sweep_ctrl_if #(
    parameter int PW = 19,
    parameter int DW = 16,
    parameter int AW = 32
);
    logic                 start;
    logic                 abort;
    logic [PW-1:0]        f_start;
    logic [PW-1:0]        f_step;
    logic [15:0]          n_steps;
    logic [15:0]          settle_cnt;
    logic [15:0]          dwell_cnt;
    logic                 ce_in;
    logic signed [DW-1:0] i_in;
    logic signed [DW-1:0] q_in;
    logic [PW-1:0]        phase_inc;
    logic                 busy;
    logic                 res_valid;
    logic                 res_ready;
    logic signed [AW-1:0] res_i;
    logic signed [AW-1:0] res_q;
    logic [15:0]          res_idx;
    logic                 done;

    modport master (
        output start, abort, f_start, f_step, n_steps, settle_cnt, dwell_cnt,
               ce_in, i_in, q_in, res_ready,
        input  phase_inc, busy, res_valid, res_i, res_q, res_idx, done
    );

    modport slave (
        input  start, abort, f_start, f_step, n_steps, settle_cnt, dwell_cnt,
               ce_in, i_in, q_in, res_ready,
        output phase_inc, busy, res_valid, res_i, res_q, res_idx, done
    );
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: stepped-frequency sweep controller. For each of n_steps points it
// programs the phase increment, discards settle_cnt decimated samples, sums the
// next dwell_cnt I/Q samples and offers the sums on a valid/ready result channel.
// Ports:
//   sys_clk : sole clock, rising edge
//   rst_n   : synchronous reset, active-high despite the name
//   bus     : sweep_ctrl_if.slave -- start/abort, captured sweep configuration,
//             ce_in/i_in/q_in samples, phase_inc, busy, res_* channel, done pulse
module sweep_ctrl #(
    parameter int PW = 19,
    parameter int DW = 16,
    parameter int AW = 32
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    sweep_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_EMIT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [PW-1:0]        step_q, step_d;
    logic [15:0]          nsteps_q, nsteps_d;
    logic [15:0]          settle_q, settle_d;
    logic [15:0]          dwell_q, dwell_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          idx_q, idx_d;
    logic signed [AW-1:0] acc_i_q, acc_i_d;
    logic signed [AW-1:0] acc_q_q, acc_q_d;

    logic [15:0]          dwell_eff;
    logic [15:0]          cnt_inc;
    logic signed [AW-1:0] i_ext;
    logic signed [AW-1:0] q_ext;

    // A zero dwell still accumulates one sample.
    assign dwell_eff = (dwell_q == '0) ? 16'd1 : dwell_q;
    assign cnt_inc   = cnt_q + 16'd1;
    assign i_ext     = {{(AW-DW){bus.i_in[DW-1]}}, bus.i_in};
    assign q_ext     = {{(AW-DW){bus.q_in[DW-1]}}, bus.q_in};

    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            step_q   <= '0;
            nsteps_q <= '0;
            settle_q <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
            nsteps_q <= nsteps_d;
            settle_q <= settle_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        step_d   = step_q;
        nsteps_d = nsteps_q;
        settle_d = settle_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    step_d   = bus.f_step;
                    nsteps_d = bus.n_steps;
                    settle_d = bus.settle_cnt;
                    dwell_d  = bus.dwell_cnt;
                    cnt_d    = '0;
                    if (bus.n_steps == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETTLE;
                        phase_d = bus.f_start;
                        idx_d   = '0;
                    end
                end
            end
            S_SETTLE: begin
                // A strobe on the cycle that completes settling is a settle
                // sample; accumulation starts with the following strobe.
                if (settle_q == '0) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                    acc_i_d = '0;
                    acc_q_d = '0;
                end else if (bus.ce_in) begin
                    if (cnt_inc == settle_q) begin
                        state_d = S_ACCUM;
                        cnt_d   = '0;
                        acc_i_d = '0;
                        acc_q_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_ACCUM: begin
                if (bus.ce_in) begin
                    acc_i_d = acc_i_q + i_ext;
                    acc_q_d = acc_q_q + q_ext;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == dwell_eff) begin
                        state_d = S_EMIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_EMIT: begin
                if (bus.res_ready) begin
                    if (idx_q == nsteps_q - 16'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETTLE;
                        phase_d = phase_q + step_q;
                        idx_d   = idx_q + 16'd1;
                        cnt_d   = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any transition above and leaves phase_inc untouched.
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            phase_d = phase_q;
            idx_d   = idx_q;
            cnt_d   = '0;
            acc_i_d = acc_i_q;
            acc_q_d = acc_q_q;
        end
    end

    assign bus.phase_inc = phase_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.res_valid = (state_q == S_EMIT);
    assign bus.done      = (state_q == S_DONE);
    assign bus.res_i     = acc_i_q;
    assign bus.res_q     = acc_q_q;
    assign bus.res_idx   = idx_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: randomized and directed stimulus for sweep_ctrl, checked every
// cycle against a reference model that reasons about sample strobes per point
// (discard the first settle strobes after a retune, sum the next dwell strobes).
module tb_sweep_ctrl;

    localparam int PW = 19;
    localparam int DW = 16;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sweep_ctrl_if #(.PW(PW), .DW(DW), .AW(AW)) bus ();

    sweep_ctrl #(.PW(PW), .DW(DW), .AW(AW)) dut (
        .sys_clk (clk),
        .rst_n   (rst),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // drive values for the current cycle
    logic                 drv_rst = 1'b1;
    logic                 drv_start = 1'b0;
    logic                 drv_abort = 1'b0;
    logic [PW-1:0]        drv_fs = '0;
    logic [PW-1:0]        drv_fst = '0;
    logic [15:0]          drv_n = '0;
    logic [15:0]          drv_set = '0;
    logic [15:0]          drv_dw = '0;
    logic                 drv_ce = 1'b0;
    logic signed [DW-1:0] drv_i = '0;
    logic signed [DW-1:0] drv_q = '0;
    logic                 drv_ready = 1'b0;

    // reference model
    int          k = 0;
    bit          m_busy = 0, m_valid = 0, m_done = 0, m_collect = 0;
    bit          m_chk_reset = 1;
    int unsigned m_phase = 0, m_step = 0;
    int          m_idx = 0, m_n = 0, m_settle = 0, m_dwell = 1, m_retune = 0;
    int          m_exp_i = 0, m_exp_q = 0;
    int          si[$], sq[$];

    // observations at each handshake, and done pulses seen
    int hs_i[$], hs_q[$], hs_idx[$], hs_ph[$];
    int n_done = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic apply_drives();
        rst            = drv_rst;
        bus.start      = drv_start;
        bus.abort      = drv_abort;
        bus.f_start    = drv_fs;
        bus.f_step     = drv_fst;
        bus.n_steps    = drv_n;
        bus.settle_cnt = drv_set;
        bus.dwell_cnt  = drv_dw;
        bus.ce_in      = drv_ce;
        bus.i_in       = drv_i;
        bus.q_in       = drv_q;
        bus.res_ready  = drv_ready;
    endtask

    task automatic begin_point();
        si.delete();
        sq.delete();
        m_collect = 1;
        m_retune  = k;
    endtask

    task automatic model_update();
        int ii, qq;
        m_chk_reset = 0;
        if (drv_rst) begin
            m_busy = 0; m_valid = 0; m_done = 0; m_collect = 0;
            m_phase = 0; m_idx = 0; m_chk_reset = 1;
        end else if (m_busy && drv_abort) begin
            m_busy = 0; m_valid = 0; m_done = 0; m_collect = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (drv_start && !drv_abort) begin
                m_n      = int'(drv_n);
                m_settle = int'(drv_set);
                m_dwell  = (drv_dw == 0) ? 1 : int'(drv_dw);
                m_step   = int'(drv_fst);
                m_busy   = 1;
                if (m_n == 0) begin
                    m_done = 1;
                end else begin
                    m_phase = int'(drv_fs);
                    m_idx   = 0;
                    begin_point();
                end
            end
        end else if (m_valid) begin
            if (drv_ready) begin
                m_valid = 0;
                if (m_idx == m_n - 1) begin
                    m_done = 1;
                end else begin
                    m_idx++;
                    m_phase = (m_phase + m_step) % (1 << PW);
                    begin_point();
                end
            end
        end else if (m_collect && drv_ce && (k > m_retune + ((m_settle == 0) ? 1 : 0))) begin
            si.push_back(int'(drv_i));
            sq.push_back(int'(drv_q));
            if (si.size() == m_settle + m_dwell) begin
                ii = 0; qq = 0;
                for (int j = m_settle; j < m_settle + m_dwell; j++) begin
                    ii += si[j];
                    qq += sq[j];
                end
                m_exp_i = ii; m_exp_q = qq;
                m_valid = 1; m_collect = 0;
            end
        end
    endtask

    // One clock: observe post-edge outputs, drive this cycle's inputs, advance model.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
        check("busy", bus.busy, m_busy);
        check("res_valid", bus.res_valid, m_valid);
        check("done", bus.done, m_done);
        check("phase_inc", bus.phase_inc, m_phase);
        if (m_valid) begin
            check("res_i", bus.res_i, m_exp_i);
            check("res_q", bus.res_q, m_exp_q);
            check("res_idx", bus.res_idx, m_idx);
        end
        if (m_chk_reset) begin
            check("rst_res_i", bus.res_i, 0);
            check("rst_res_q", bus.res_q, 0);
            check("rst_res_idx", bus.res_idx, 0);
        end
        if (bus.done) n_done++;
        if (m_valid && drv_ready && !drv_abort && !drv_rst) begin
            hs_i.push_back(int'(bus.res_i));
            hs_q.push_back(int'(bus.res_q));
            hs_idx.push_back(int'(bus.res_idx));
            hs_ph.push_back(int'(bus.phase_inc));
        end
        apply_drives();
        model_update();
    endtask

    task automatic clear_drives();
        drv_rst = 0; drv_start = 0; drv_abort = 0; drv_ce = 0; drv_ready = 0;
        drv_i = '0; drv_q = '0;
    endtask

    task automatic clear_log();
        hs_i.delete(); hs_q.delete(); hs_idx.delete(); hs_ph.delete();
        n_done = 0;
    endtask

    task automatic run_sweep(input int fs, input int fst, input int n, input int set,
                             input int dw, input int period, input int ival,
                             input int qval, input int hold, input bit do_abort,
                             input bit do_rst, input bit noise, input int budget);
        int  cyc;
        int  hold_left;
        bit  abort_left, rst_left;
        clear_log();
        clear_drives();
        drv_fs = PW'(fs); drv_fst = PW'(fst); drv_n = 16'(n);
        drv_set = 16'(set); drv_dw = 16'(dw);
        drv_start = 1;
        step();
        drv_start = 0;
        hold_left = hold; abort_left = do_abort; rst_left = do_rst; cyc = 0;
        while (m_busy && cyc < budget) begin
            drv_ce = ((cyc % period) == period - 1);
            drv_i = DW'(ival); drv_q = DW'(qval);
            drv_ready = 1; drv_abort = 0; drv_rst = 0; drv_start = 0;
            if (m_valid && hold_left > 0) begin
                drv_ready = 0;
                hold_left--;
            end
            if (abort_left && m_collect && si.size() > m_settle) begin
                drv_abort = 1;
                abort_left = 0;
            end
            if (rst_left && m_valid) begin
                drv_rst = 1;
                drv_ready = 0;
                rst_left = 0;
            end
            if (noise) begin
                drv_fs  = PW'($urandom); drv_fst = PW'($urandom);
                drv_n   = 16'($urandom_range(0, 9));
                drv_set = 16'($urandom_range(0, 9));
                drv_dw  = 16'($urandom_range(0, 9));
                drv_start = ($urandom_range(0, 3) == 0);
            end
            step();
            cyc++;
        end
        check("sweep_timeout", cyc < budget, 1);
        clear_drives();
        repeat (3) step();
    endtask

    initial begin
        apply_drives();
        // reset held for a few cycles
        repeat (3) step();
        clear_drives();
        step();

        // basic sweep with known answers
        run_sweep(80652, 1000, 3, 2, 4, 4, 100, -50, 0, 0, 0, 0, 200);
        check("basic_count", hs_i.size(), 3);
        for (int j = 0; j < 3; j++) begin
            if (j < hs_i.size()) begin
                check("basic_res_i", hs_i[j], 400);
                check("basic_res_q", hs_q[j], -200);
                check("basic_idx", hs_idx[j], j);
                check("basic_phase", hs_ph[j], 80652 + 1000 * j);
            end
        end
        check("basic_done", n_done, 1);

        // backpressure: result held 20 cycles while strobes keep arriving
        run_sweep(1234, 5, 2, 1, 4, 2, 100, 7, 20, 0, 0, 0, 300);
        check("bp_count", hs_i.size(), 2);
        if (hs_i.size() > 0) check("bp_res_i", hs_i[0], 400);
        check("bp_done", n_done, 1);

        // abort mid-accumulation, then a clean sweep
        run_sweep(4321, 10, 3, 1, 8, 2, 33, 44, 0, 1, 0, 0, 300);
        check("abort_results", hs_i.size(), 0);
        check("abort_done", n_done, 0);
        check("abort_phase", bus.phase_inc, 4321);
        run_sweep(80652, 1000, 3, 2, 4, 4, 100, -50, 0, 0, 0, 0, 200);
        check("after_abort_count", hs_i.size(), 3);

        // zero points
        run_sweep(777, 1, 0, 2, 4, 1, 1, 1, 0, 0, 0, 0, 20);
        check("n0_results", hs_i.size(), 0);
        check("n0_done", n_done, 1);

        // zero dwell takes a single sample
        run_sweep(100, 1, 1, 0, 0, 1, -1234, 567, 0, 0, 0, 0, 20);
        if (hs_i.size() > 0) check("dwell0_res_i", hs_i[0], -1234);
        if (hs_q.size() > 0) check("dwell0_res_q", hs_q[0], 567);

        // phase increment wraps modulo 2^PW
        run_sweep((1 << PW) - 1, 2, 2, 0, 1, 1, 3, 3, 0, 0, 0, 0, 40);
        check("wrap_count", hs_ph.size(), 2);
        if (hs_ph.size() > 1) check("wrap_phase", hs_ph[1], 1);

        // starts with other settings during a sweep are ignored
        run_sweep(80652, 1000, 3, 2, 4, 4, 100, -50, 0, 0, 0, 1, 200);
        check("busy_start_count", hs_i.size(), 3);
        if (hs_i.size() > 2) check("busy_start_res_i", hs_i[2], 400);

        // synchronous reset while a result is pending
        run_sweep(999, 3, 2, 1, 2, 1, 9, 9, 5, 0, 1, 0, 100);
        check("rst_emit_results", hs_i.size(), 0);
        check("rst_emit_done", n_done, 0);

        // longest dwell at full-scale input stays in range
        run_sweep(0, 0, 1, 0, 65535, 1, 32767, -32768, 0, 0, 0, 0, 70000);
        if (hs_i.size() > 0) check("ovf_res_i", hs_i[0], 2147385345);
        if (hs_q.size() > 0) check("ovf_res_q", hs_q[0], -2147450880);

        // randomized traffic
        clear_log();
        for (int t = 0; t < 4000; t++) begin
            drv_rst   = ($urandom_range(0, 999) == 0);
            drv_start = ($urandom_range(0, 5) == 0);
            drv_abort = ($urandom_range(0, 149) == 0);
            drv_fs    = PW'($urandom);
            drv_fst   = PW'($urandom);
            drv_n     = 16'($urandom_range(0, 4));
            drv_set   = 16'($urandom_range(0, 3));
            drv_dw    = 16'($urandom_range(0, 4));
            drv_ce    = 1'($urandom_range(0, 1));
            drv_i     = DW'($urandom);
            drv_q     = DW'($urandom);
            drv_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        clear_drives();
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
